// File: rtl/reaction_controller.sv
// Master sequencer for the reaction-time tester: random pre-start wait, per-trial
// reaction timing in ms, and per-player averaging over 2**TRIALS_LOG2 trials.
module reaction_controller #(
  parameter int MIN_WAIT_MS = 1000,
  parameter int RAND_BITS   = 11,
  parameter int TRIALS_LOG2 = 2,
  parameter int MAX_MS      = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       btn_start,
  input  logic       btn_react,
  output logic [2:0] machine_state,
  output logic       cur_player,
  output logic [9:0] react_time,
  output logic [9:0] avr_react_time_A,
  output logic [9:0] avr_react_time_B,
  output logic       led_go,
  output logic       false_start
);

  localparam int DLY_W = $clog2(MIN_WAIT_MS + 2**RAND_BITS);
  localparam int SUM_W = 10 + TRIALS_LOG2;
  localparam int CNT_W = TRIALS_LOG2 + 1;
  localparam logic [CNT_W-1:0] TRIALS = CNT_W'(2**TRIALS_LOG2);
  localparam logic [9:0]       MAX_T  = 10'(MAX_MS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    CLR_CNT1 = 3'd2,
    START    = 3'd3,
    STORAGE  = 3'd4,
    CLR_CNT2 = 3'd5,
    AVERAGE  = 3'd6,
    COMPARE  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic               player_q, player_d;
  logic [9:0]         react_q, react_d;
  logic [9:0]         avg_a_q, avg_a_d;
  logic [9:0]         avg_b_q, avg_b_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   trial_q, trial_d;
  logic               fs_q, fs_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [15:0]        lfsr_q;
  logic [DLY_W-1:0]   dly_load;
  logic [9:0]         avg_val;

  assign dly_load = DLY_W'(MIN_WAIT_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
  assign avg_val  = 10'(sum_q >> TRIALS_LOG2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      player_q <= 1'b1;
      react_q  <= '0;
      avg_a_q  <= '0;
      avg_b_q  <= '0;
      sum_q    <= '0;
      trial_q  <= '0;
      fs_q     <= 1'b0;
      dly_q    <= '0;
      lfsr_q   <= 16'hACE1;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      react_q  <= react_d;
      avg_a_q  <= avg_a_d;
      avg_b_q  <= avg_b_d;
      sum_q    <= sum_d;
      trial_q  <= trial_d;
      fs_q     <= fs_d;
      dly_q    <= dly_d;
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    react_d  = react_q;
    avg_a_d  = avg_a_q;
    avg_b_d  = avg_b_q;
    sum_d    = sum_q;
    trial_d  = trial_q;
    fs_d     = fs_q;
    dly_d    = dly_q;
    case (state_q)
      IDLE: begin
        if (btn_start) begin
          state_d  = WAIT;
          dly_d    = dly_load;
          sum_d    = '0;
          trial_d  = '0;
          react_d  = '0;
          avg_a_d  = '0;
          avg_b_d  = '0;
          player_d = 1'b1;
        end
      end
      WAIT: begin
        // an early press restarts the wait and outranks a same-cycle expiry
        if (btn_react) begin
          dly_d = dly_load;
          fs_d  = 1'b1;
        end else if (tick_1ms) begin
          if (dly_q == '0) begin
            state_d = CLR_CNT1;
            fs_d    = 1'b0;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
      end
      CLR_CNT1: begin
        react_d = '0;
        state_d = START;
      end
      START: begin
        if (btn_react || (tick_1ms && react_q == MAX_T)) begin
          state_d = STORAGE;
          sum_d   = sum_q + SUM_W'(react_q);
          trial_d = trial_q + 1'b1;
        end else if (tick_1ms) begin
          react_d = react_q + 10'd1;
        end
      end
      STORAGE: begin
        if (btn_start) begin
          if (trial_q == TRIALS) begin
            state_d = AVERAGE;
            if (player_q) avg_a_d = avg_val;
            else          avg_b_d = avg_val;
          end else begin
            state_d = WAIT;
            dly_d   = dly_load;
          end
        end
      end
      AVERAGE: begin
        if (btn_start) state_d = player_q ? CLR_CNT2 : COMPARE;
      end
      CLR_CNT2: begin
        sum_d    = '0;
        trial_d  = '0;
        react_d  = '0;
        player_d = 1'b0;
        state_d  = WAIT;
        dly_d    = dly_load;
      end
      COMPARE: begin
        if (btn_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign machine_state    = state_q;
  assign cur_player       = player_q;
  assign react_time       = react_q;
  assign avr_react_time_A = avg_a_q;
  assign avr_react_time_B = avg_b_q;
  assign led_go           = (state_q == START);
  assign false_start      = fs_q;

endmodule

// File: tb/tb_reaction_controller.sv
// Directed bench for reaction_controller: full two-player session, false start,
// tick/press priority, timeout saturation and asynchronous reset.
module tb_reaction_controller;
  localparam int MINW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_react = 1'b0;
  logic [2:0] machine_state;
  logic       cur_player;
  logic [9:0] react_time;
  logic [9:0] avr_react_time_A;
  logic [9:0] avr_react_time_B;
  logic       led_go;
  logic       false_start;

  int n_assert = 0;
  int n_fail   = 0;
  int dly;
  logic [15:0] m;

  reaction_controller #(
    .MIN_WAIT_MS(4), .RAND_BITS(2), .TRIALS_LOG2(1), .MAX_MS(999)
  ) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .btn_start(btn_start),
    .btn_react(btn_react), .machine_state(machine_state), .cur_player(cur_player),
    .react_time(react_time), .avr_react_time_A(avr_react_time_A),
    .avr_react_time_B(avr_react_time_B), .led_go(led_go), .false_start(false_start)
  );

  always #5 clk = ~clk;

  // reference LFSR: Fibonacci, taps 16,14,13,11, seed ACE1
  always @(posedge clk or posedge rst) begin
    if (rst) m <= 16'hACE1;
    else     m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      idle(9);
      tick_1ms = 1'b1;
      step();
      tick_1ms = 1'b0;
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
  endtask

  task automatic press_react();
    btn_react = 1'b1;
    step();
    btn_react = 1'b0;
  endtask

  // WAIT -> CLR_CNT1 -> START after d+1 ticks
  task automatic run_to_start(input int d, input string tag);
    ticks(d);
    chk({tag, "_still_wait"}, int'(machine_state), 1);
    ticks(1);
    chk({tag, "_clr_cnt1"}, int'(machine_state), 2);
    step();
    chk({tag, "_start"}, int'(machine_state), 3);
    chk({tag, "_led_go"}, int'(led_go), 1);
    chk({tag, "_react0"}, int'(react_time), 0);
  endtask

  task automatic start_to_wait(input string tag);
    dly = MINW + int'(m[1:0]);
    press_start();
    chk({tag, "_wait"}, int'(machine_state), 1);
  endtask

  task automatic trial(input int t, input string tag);
    run_to_start(dly, tag);
    ticks(t);
    press_react();
    chk({tag, "_storage"}, int'(machine_state), 4);
    chk({tag, "_react"}, int'(react_time), t);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    chk("rst_state", int'(machine_state), 0);
    chk("rst_player", int'(cur_player), 1);
    chk("rst_react", int'(react_time), 0);
    chk("rst_avg_a", int'(avr_react_time_A), 0);
    chk("rst_avg_b", int'(avr_react_time_B), 0);
    chk("rst_fs", int'(false_start), 0);
    chk("rst_led", int'(led_go), 0);
    idle(3);

    // player A: 37 and 52 -> 44
    start_to_wait("a1");
    trial(37, "a1");
    chk("a1_led_off", int'(led_go), 0);
    start_to_wait("a2");
    trial(52, "a2");
    press_start();
    chk("avg_state", int'(machine_state), 6);
    chk("avg_a_44", int'(avr_react_time_A), 44);
    chk("avg_player_a", int'(cur_player), 1);

    // switch to player B: 20 and 31 -> 25
    press_start();
    chk("clr2_state", int'(machine_state), 5);
    dly = MINW + int'(m[1:0]);
    step();
    chk("clr2_to_wait", int'(machine_state), 1);
    chk("player_b", int'(cur_player), 0);
    chk("clr2_react0", int'(react_time), 0);
    trial(20, "b1");
    start_to_wait("b2");
    trial(31, "b2");
    press_start();
    chk("avg_b_25", int'(avr_react_time_B), 25);
    chk("avg_a_kept", int'(avr_react_time_A), 44);
    press_start();
    chk("compare_state", int'(machine_state), 7);
    press_react();
    chk("compare_ignores_react", int'(machine_state), 7);
    chk("cmp_avg_a", int'(avr_react_time_A), 44);
    chk("cmp_avg_b", int'(avr_react_time_B), 25);
    press_start();
    chk("idle_again", int'(machine_state), 0);
    chk("idle_avg_a_kept", int'(avr_react_time_A), 44);
    start_to_wait("s2");
    chk("s2_avg_a_clr", int'(avr_react_time_A), 0);
    chk("s2_avg_b_clr", int'(avr_react_time_B), 0);
    chk("s2_player_a", int'(cur_player), 1);

    // false start, then normal expiry from the reloaded delay
    idle(3);
    dly = MINW + int'(m[1:0]);
    press_react();
    chk("fs_set", int'(false_start), 1);
    chk("fs_state_wait", int'(machine_state), 1);
    run_to_start(dly, "fs");
    chk("fs_cleared", int'(false_start), 0);

    // press coincident with tick at count 15 stores 15
    ticks(15);
    idle(9);
    btn_react = 1'b1;
    tick_1ms = 1'b1;
    step();
    btn_react = 1'b0;
    tick_1ms = 1'b0;
    chk("prio_storage", int'(machine_state), 4);
    chk("prio_react15", int'(react_time), 15);

    // timeout saturates at 999, leaves on the 1000th tick
    start_to_wait("to");
    run_to_start(dly, "to");
    ticks(999);
    chk("to_still_start", int'(machine_state), 3);
    chk("to_react999", int'(react_time), 999);
    ticks(1);
    chk("to_storage", int'(machine_state), 4);
    chk("to_react_sat", int'(react_time), 999);
    press_start();
    chk("to_avg_a_507", int'(avr_react_time_A), 507);

    // player B with nonzero sum, then async reset mid-START
    press_start();
    dly = MINW + int'(m[1:0]);
    step();
    trial(10, "r1");
    start_to_wait("r2");
    run_to_start(dly, "r2");
    ticks(20);
    chk("r2_react20", int'(react_time), 20);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_state", int'(machine_state), 0);
    chk("arst_react", int'(react_time), 0);
    chk("arst_player", int'(cur_player), 1);
    chk("arst_avg_a", int'(avr_react_time_A), 0);
    chk("arst_led", int'(led_go), 0);
    step();
    rst = 1'b0;
    idle(2);
    press_react();
    chk("idle_ignores_react", int'(machine_state), 0);
    chk("idle_react0", int'(react_time), 0);

    // no partial sum survived: 6 and 9 -> 7
    start_to_wait("p1");
    trial(6, "p1");
    start_to_wait("p2");
    trial(9, "p2");
    press_start();
    chk("post_rst_avg_a_7", int'(avr_react_time_A), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_controller.md
Name: reaction_controller

Overview:
- Master sequencer for the reaction-time tester. Steps the 8-state machine_state consumed by the display path and selects cur_player.
- Generates the random pre-start delay and measures each reaction in ms.
- Accumulates TRIALS results per player and produces avr_react_time_A/B for the display and compare stage.
- Sits between the debounced button/tick logic and the display block.

Parameters:
- MIN_WAIT_MS, 1000, fixed part of the random wait in ms.
- RAND_BITS, 11, LFSR bits added to the wait, giving a random part of 0..2^RAND_BITS-1 ms.
- TRIALS_LOG2, 2, log2 of trials per player (default 4).
- MAX_MS, 999, saturation and timeout value of the reaction counter.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous reset, active-high.
- tick_1ms, in, 1: one-cycle pulse every 1 ms, synchronous to clk.
- btn_start, in, 1: debounced one-cycle pulse.
- btn_react, in, 1: debounced one-cycle pulse.
- machine_state, out, 3: IDLE=0, WAIT=1, CLR_CNT1=2, START=3, STORAGE=4, CLR_CNT2=5, AVERAGE=6, COMPARE=7.
- cur_player, out, 1: PLAYER_A=1, PLAYER_B=0.
- react_time, out, 10: live or latched reaction time in ms.
- avr_react_time_A, out, 10: player A average in ms.
- avr_react_time_B, out, 10: player B average in ms.
- led_go, out, 1: high exactly while machine_state==START.
- false_start, out, 1: high in WAIT after an early press.

Behaviour:
- Reset: state=IDLE, cur_player=A, react_time=0, both averages=0, sum=0, trial_cnt=0, false_start=0, LFSR=16'hACE1.
- All outputs are registered or decoded from the state register; no input-to-output combinational path.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk and is never zero.
- Wait load value: MIN_WAIT_MS + lfsr[RAND_BITS-1:0] into the delay counter, sized to hold the maximum.
- IDLE:
  - btn_start -> WAIT.
  - On that edge: load delay; clear sum, trial_cnt, react_time and both averages; set cur_player=A.
  - btn_react is ignored.
- WAIT:
  - The delay counter decrements on each tick_1ms.
  - When the counter is 0 and tick_1ms is high -> CLR_CNT1.
  - btn_react: reload delay with the current LFSR value, set false_start=1, stay in WAIT. This has priority over expiry in the same cycle.
  - false_start clears on leaving WAIT.
- CLR_CNT1: react_time<=0, one cycle, unconditional -> START.
- START:
  - On tick_1ms, react_time increments.
  - btn_react -> STORAGE. In the same cycle react_time does not increment: the captured value is the pre-tick count. btn_react wins over tick_1ms.
  - Timeout: if react_time==MAX_MS and tick_1ms is high -> STORAGE with react_time held at MAX_MS (saturation; never exceeds 999).
  - btn_start is ignored.
- STORAGE:
  - On entry (transition cycle): sum<=sum+react_time, width 10+TRIALS_LOG2, no overflow possible; trial_cnt<=trial_cnt+1. react_time is held.
  - btn_start with trial_cnt==2^TRIALS_LOG2 -> AVERAGE. On that edge the average for cur_player <= sum>>TRIALS_LOG2 (truncation).
  - Otherwise btn_start -> WAIT with a fresh delay load.
- AVERAGE: holds.
  - btn_start with cur_player==A -> CLR_CNT2.
  - btn_start with cur_player==B -> COMPARE.
- CLR_CNT2: sum<=0, trial_cnt<=0, react_time<=0, cur_player<=B; one cycle -> WAIT, loading delay on that edge.
- COMPARE:
  - Holds both averages.
  - btn_start -> IDLE. Averages are retained until the next IDLE start clears them.
- Simultaneous btn_start and btn_react: each state uses only its listed input; unlisted pulses are dropped.
- Asynchronous rst mid-operation returns everything to reset values immediately; no partial sums survive.

Test Plan:
- Sim parameters MIN_WAIT_MS=4, RAND_BITS=2, TRIALS_LOG2=1, clk with tick_1ms every 10 cycles.
  - Reset, then btn_start -> WAIT.
  - Delay counter = 4+lfsr[1:0]. After (delay+1) ticks -> CLR_CNT1 for 1 cycle, then START with led_go=1.
- Reaction and averaging:
  - In START, press btn_react after 37 ticks -> STORAGE, react_time=37.
  - Second trial of 52 -> btn_start -> AVERAGE, avr_react_time_A=44 (89>>1), cur_player=A.
- Player switch and compare:
  - btn_start from AVERAGE(A) -> CLR_CNT2 (1 cycle), cur_player=B, sum=0, then WAIT.
  - B trials 20 and 31 -> avr_react_time_B=25.
  - btn_start -> COMPARE with avr A=44 and B=25 held.
- False start: btn_react during WAIT -> false_start=1, state stays WAIT, delay reloaded. Normal expiry then reaches CLR_CNT1 with false_start=0.
- Timeout and priority:
  - No press in START -> react_time stops at 999 and the state goes to STORAGE on the 1000th tick.
  - btn_react coincident with tick_1ms at count 15 -> stored value 15.
- Reset:
  - Assert rst while in START with react_time=20 and sum nonzero -> all outputs to reset values on the same edge, asynchronously.
  - After deassert, btn_react is ignored in IDLE.
